// File: rtl/bpe_pkg.sv
// Shared types and defaults for the BPE token encoder.
package bpe_pkg;

    // Top-level encoder FSM states. The entry walker also decodes these
    // to know which compare/skip step the top is in.
    typedef enum logic [3:0] {
        IDLE,
        CHK_END,
        ENT_START,
        CMP,
        SKIP,
        RESOLVE,
        CODE_RD,
        EMIT,
        FIN
    } bpe_state_t;

    // Code written when no vocab entry matches at the current position.
    localparam int DEF_UNK_CODE = 0;

endpackage

// File: rtl/bpe_entry_cmp.sv
// Per-entry vocab walker: owns the vocab read pointer and the match length.
// It evaluates ENT_START/CMP/SKIP steps once their read data has landed and
// reports the outcome to the top FSM.
module bpe_entry_cmp
    import bpe_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int VOCAB_ADDR_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  bpe_state_t                  state,
    input  logic                        data_ok,    // read data for this step is valid
    input  logic                        init,       // restart at entry 0 for a new position
    input  logic                        in_zero,    // input index ran past the string memory
    input  logic [DATA_WIDTH-1:0]       voc_data,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic [VOCAB_ADDR_WIDTH-1:0] voc_addr,
    output logic                        table_end,  // empty entry reached
    output logic                        entry_end,  // terminator reached (match when match_len>0)
    output logic                        mismatch,   // compare failed, skip rest of entry
    output logic                        step,       // chars equal, keep comparing
    output logic                        addr_wrap,  // the next vocab read would pass the top address
    output logic [VOCAB_ADDR_WIDTH:0]   match_len
);

    localparam int VW = VOCAB_ADDR_WIDTH;

    // rd always points at the vocab byte being read; after an entry ends it
    // lands on the next entry's first byte, so no separate base is kept.
    logic [VW:0]           rd;
    logic [VW:0]           j;
    logic [VW:0]           rd_inc;
    logic [DATA_WIDTH-1:0] in_ch;
    logic                  voc_nul;

    assign rd_inc    = rd + (VW+1)'(1);
    assign addr_wrap = rd_inc[VW];
    assign voc_addr  = rd[VW-1:0];
    assign in_ch     = in_zero ? '0 : in_data;
    assign voc_nul   = (voc_data == '0);

    // Classify the current step from the returned vocab/input characters.
    always_comb begin
        table_end = 1'b0;
        entry_end = 1'b0;
        mismatch  = 1'b0;
        step      = 1'b0;
        match_len = '0;
        if (data_ok) begin
            case (state)
                ENT_START: table_end = voc_nul;
                CMP: begin
                    if (voc_nul) begin
                        if (j != '0) begin
                            entry_end = 1'b1;
                            match_len = j;
                        end else begin
                            table_end = 1'b1;
                        end
                    end else if (voc_data == in_ch) begin
                        step = 1'b1;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
                SKIP:    entry_end = voc_nul;
                default: ;
            endcase
        end
    end

    // Advance the vocab pointer and the per-entry match length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
            j  <= '0;
        end else if (init) begin
            rd <= '0;
            j  <= '0;
        end else if (data_ok) begin
            case (state)
                ENT_START: j <= '0;
                CMP: begin
                    if (step) begin
                        rd <= rd_inc;
                        j  <= j + (VW+1)'(1);
                    end else if (entry_end || mismatch) begin
                        rd <= rd_inc;
                        j  <= '0;
                    end
                end
                SKIP:    rd <= rd_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bpe_token_encoder.sv
// Greedy vocabulary tokeniser: walks a zero-terminated input string against a
// packed zero-terminated vocab table and writes one code per token. Every
// memory read costs two cycles: the address is registered, and the wt flag
// holds the FSM for one cycle while the data comes back.
module bpe_token_encoder
    import bpe_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 4,
    parameter int VOCAB_ADDR_WIDTH = 4,
    parameter int CODE_WIDTH       = 8,
    parameter int OUT_ADDR_WIDTH   = 4,
    parameter int UNK_CODE         = DEF_UNK_CODE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        mode_longest,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [OUT_ADDR_WIDTH:0]     token_count,
    output logic [ADDR_WIDTH-1:0]       in_addr,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic [VOCAB_ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0]       voc_data,
    output logic [VOCAB_ADDR_WIDTH-1:0] code_addr,
    input  logic [CODE_WIDTH-1:0]       code_data,
    output logic                        out_we,
    output logic [OUT_ADDR_WIDTH-1:0]   out_addr,
    output logic [CODE_WIDTH-1:0]       out_data
);

    localparam int AW = ADDR_WIDTH;
    localparam int VW = VOCAB_ADDR_WIDTH;
    localparam int OW = OUT_ADDR_WIDTH;

    bpe_state_t  state, state_n;
    logic        wt, wt_n;
    logic [AW:0] pos;       // extra bit flags a position past the input memory
    logic [AW:0] in_idx;    // input byte being read (pos + j during a compare)
    logic [VW-1:0] k, best_k;
    logic [VW:0] best_len;
    logic [OW:0] count;
    logic        mode;

    logic accept, init_ent, k_inc, in_step, rec_best, set_err;
    logic go_code, go_emit, wr_fire, fin;

    logic        w_table_end, w_entry_end, w_mismatch, w_step, w_wrap;
    logic [VW:0] w_match_len;

    assign in_addr     = in_idx[AW-1:0];
    assign token_count = count;

    bpe_entry_cmp #(
        .DATA_WIDTH       (DATA_WIDTH),
        .VOCAB_ADDR_WIDTH (VOCAB_ADDR_WIDTH)
    ) u_walk (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .data_ok   (!wt),
        .init      (init_ent),
        .in_zero   (in_idx[AW]),
        .voc_data  (voc_data),
        .in_data   (in_data),
        .voc_addr  (voc_addr),
        .table_end (w_table_end),
        .entry_end (w_entry_end),
        .mismatch  (w_mismatch),
        .step      (w_step),
        .addr_wrap (w_wrap),
        .match_len (w_match_len)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic and datapath strobes; nothing moves while a read is in flight.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        init_ent = 1'b0;
        k_inc    = 1'b0;
        in_step  = 1'b0;
        rec_best = 1'b0;
        set_err  = 1'b0;
        go_code  = 1'b0;
        go_emit  = 1'b0;
        wr_fire  = 1'b0;
        fin      = 1'b0;
        if (!wt) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        accept  = 1'b1;
                        state_n = CHK_END;
                    end
                end
                CHK_END: begin
                    if (pos[AW] || in_data == '0) begin
                        state_n = FIN;
                    end else begin
                        init_ent = 1'b1;
                        state_n  = ENT_START;
                    end
                end
                ENT_START: state_n = w_table_end ? RESOLVE : CMP;
                CMP: begin
                    if (w_step) begin
                        in_step = 1'b1;
                        if (w_wrap) begin
                            set_err = 1'b1;
                            state_n = RESOLVE;
                        end
                    end else if (w_entry_end) begin
                        rec_best = (w_match_len > best_len);
                        if (!mode) begin
                            state_n = RESOLVE;
                        end else if (w_wrap) begin
                            set_err = 1'b1;
                            state_n = RESOLVE;
                        end else begin
                            k_inc   = 1'b1;
                            state_n = ENT_START;
                        end
                    end else if (w_mismatch) begin
                        if (w_wrap) begin
                            set_err = 1'b1;
                            state_n = RESOLVE;
                        end else begin
                            state_n = SKIP;
                        end
                    end else begin
                        state_n = RESOLVE;
                    end
                end
                SKIP: begin
                    if (w_wrap) begin
                        set_err = 1'b1;
                        state_n = RESOLVE;
                    end else if (w_entry_end) begin
                        k_inc   = 1'b1;
                        state_n = ENT_START;
                    end
                end
                RESOLVE: begin
                    if (best_len != '0) begin
                        go_code = 1'b1;
                        state_n = CODE_RD;
                    end else begin
                        go_emit = 1'b1;
                        state_n = EMIT;
                    end
                end
                CODE_RD: begin
                    go_emit = 1'b1;
                    state_n = EMIT;
                end
                EMIT: begin
                    if (count[OW]) begin
                        set_err = 1'b1;
                        state_n = FIN;
                    end else begin
                        wr_fire = 1'b1;
                        state_n = CHK_END;
                    end
                end
                FIN: begin
                    fin     = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
        wt_n = !wt && (state_n inside {CHK_END, ENT_START, CMP, SKIP, CODE_RD});
    end

    // Datapath registers: position, best match, output write port and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt        <= 1'b0;
            pos       <= '0;
            in_idx    <= '0;
            k         <= '0;
            best_k    <= '0;
            best_len  <= '0;
            count     <= '0;
            mode      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            code_addr <= '0;
        end else begin
            wt     <= wt_n;
            out_we <= 1'b0;
            if (accept) begin
                pos    <= '0;
                in_idx <= '0;
                k      <= '0;
                count  <= '0;
                err    <= 1'b0;
                done   <= 1'b0;
                busy   <= 1'b1;
                mode   <= mode_longest;
            end
            if (init_ent) begin
                in_idx   <= pos;
                k        <= '0;
                best_len <= '0;
            end
            if (k_inc) begin
                k      <= k + VW'(1);
                in_idx <= pos;
            end
            if (in_step) in_idx <= in_idx + (AW+1)'(1);
            if (rec_best) begin
                best_k   <= k;
                best_len <= w_match_len;
            end
            if (set_err) err <= 1'b1;
            if (go_code) code_addr <= best_k;
            if (go_emit) begin
                // A full output memory suppresses the strobe; EMIT then flags err.
                out_we   <= !count[OW];
                out_addr <= count[OW-1:0];
                if (state == CODE_RD) begin
                    out_data <= code_data;
                    pos      <= pos + (AW+1)'(best_len);
                end else begin
                    out_data <= CODE_WIDTH'(UNK_CODE);
                    pos      <= pos + (AW+1)'(1);
                end
            end
            if (wr_fire) begin
                count  <= count + (OW+1)'(1);
                in_idx <= pos;
            end
            if (fin) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule
